// File: rtl/lib_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lib_arbiter_pkg
// Shared sizing constants for the pixel/row/column arbitration blocks.
//   COLS    : number of pixel columns served by one row
//   COL_ADD : width of a column index
// ---------------------------------------------------------------------------
package lib_arbiter_pkg;
    localparam int COLS    = 8;
    localparam int COL_ADD = 3;
endpackage

// File: rtl/pixel_row_requester.sv
// ---------------------------------------------------------------------------
// pixel_row_requester
// Collects per-column pixel events for one row, requests the row arbiter,
// then lets the column arbiter walk the pending columns and emits one event
// per column grant.
//
// Configuration macro: PIXEL_REFRACT_EN
//   defined   : after every scan pass the block sits in HOLD for REFRACT_CYC
//               cycles before it may request the row again
//   undefined : no HOLD state, no counter; REFRACT_CYC has no effect
//
// Ports
//   clk_i        in   1        clock, all state on the rising edge
//   reset_n_i    in   1        asynchronous active-low reset
//   evt_i        in   COLS     per-column pixel event strobe
//   pol_i        in   COLS     per-column event polarity, sampled with evt_i
//   row_req_o    out  1        request to the row arbiter
//   row_gnt_i    in   1        row grant (level)
//   col_en_o     out  1        enable to the column arbiter
//   col_req_o    out  COLS     pending columns (registered)
//   col_gnt_i    in   COLS     registered one-hot column grant
//   evt_valid_o  out  1        one-cycle event strobe
//   evt_col_o    out  COL_ADD  column index of the emitted event
//   evt_pol_o    out  1        polarity of the emitted event
//   overrun_o    out  1        one-cycle pulse: event hit an already-pending column
// ---------------------------------------------------------------------------
module pixel_row_requester
    import lib_arbiter_pkg::*;
#(
    parameter int REFRACT_CYC = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [COLS-1:0]    evt_i,
    input  logic [COLS-1:0]    pol_i,
    output logic               row_req_o,
    input  logic               row_gnt_i,
    output logic               col_en_o,
    output logic [COLS-1:0]    col_req_o,
    input  logic [COLS-1:0]    col_gnt_i,
    output logic               evt_valid_o,
    output logic [COL_ADD-1:0] evt_col_o,
    output logic               evt_pol_o,
    output logic               overrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        ROW_REQ,
        SCAN_WAIT,
        SCAN,
        DONE
`ifdef PIXEL_REFRACT_EN
        ,
        HOLD
`endif
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COLS-1:0]    pend;
    logic [COLS-1:0]    polr;
    logic [COLS-1:0]    gnt_sel;
    logic [COLS-1:0]    clr_vec;
    logic [COL_ADD-1:0] gnt_idx;
    logic               gnt_any;
    logic               scan_act;

    // Legal REFRACT_CYC values are 1..255; nothing elaborates for them.
    if (REFRACT_CYC < 1 || REFRACT_CYC > 255) begin : g_refract_range_bad
    end

    // A non-one-hot grant is reduced to its lowest set bit; the descending
    // loop lets the lowest index overwrite any higher one.
    always_comb begin
        gnt_sel = '0;
        gnt_idx = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_gnt_i[c]) begin
                gnt_sel    = '0;
                gnt_sel[c] = 1'b1;
                gnt_idx    = COL_ADD'(c);
            end
        end
    end

    // Grants only count while scanning with the row still granted; a grant
    // arriving as the row grant drops is not consumed, so that column stays
    // pending for the next pass.
    assign gnt_any   = |col_gnt_i;
    assign scan_act  = (state == SCAN) && row_gnt_i;
    assign clr_vec   = scan_act ? gnt_sel : '0;
    assign col_req_o = pend;

    // Pending/polarity store. A new event on a column that is being cleared
    // this cycle wins: it re-arms the column with the new polarity.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend <= '0;
            polr <= '0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (evt_i[c] && (!pend[c] || clr_vec[c])) begin
                    pend[c] <= 1'b1;
                    polr[c] <= pol_i[c];
                end else if (clr_vec[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    // Event output and overrun pulse. Column/polarity only update on an
    // emitted event so they hold the last value otherwise.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            evt_valid_o <= 1'b0;
            evt_col_o   <= '0;
            evt_pol_o   <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            overrun_o   <= |(evt_i & pend & ~clr_vec);
            evt_valid_o <= scan_act && gnt_any;
            if (scan_act && gnt_any) begin
                evt_col_o <= gnt_idx;
                evt_pol_o <= polr[gnt_idx];
            end
        end
    end

`ifdef PIXEL_REFRACT_EN
    logic [7:0] hold_cnt;

    // Refractory counter: loaded while in DONE, counts down through HOLD.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_cnt <= '0;
        end else if (state == DONE) begin
            hold_cnt <= 8'(REFRACT_CYC);
        end else if (state == HOLD && hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs. DONE drops both requests for one
    // cycle so the column arbiter resets its priority mask between passes.
    always_comb begin
        state_nxt = state;
        row_req_o = 1'b0;
        col_en_o  = 1'b0;
        case (state)
            IDLE: begin
                if (|pend) state_nxt = ROW_REQ;
            end
            ROW_REQ: begin
                row_req_o = 1'b1;
                if (row_gnt_i) state_nxt = SCAN_WAIT;
            end
            SCAN_WAIT: begin
                row_req_o = 1'b1;
                col_en_o  = 1'b1;
                state_nxt = SCAN;
            end
            SCAN: begin
                row_req_o = 1'b1;
                col_en_o  = 1'b1;
                if (!gnt_any || !row_gnt_i) state_nxt = DONE;
            end
            DONE: begin
`ifdef PIXEL_REFRACT_EN
                state_nxt = HOLD;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef PIXEL_REFRACT_EN
            HOLD: begin
                if (hold_cnt <= 8'd1) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pixel_row_requester.sv
// ---------------------------------------------------------------------------
// tb_pixel_row_requester
// Directed bench for pixel_row_requester. Column grants are driven by hand,
// cycle by cycle, as a registered ascending column arbiter would produce
// them. Inputs change 1 time unit after a rising edge; outputs are checked
// at the same point, i.e. they show the state produced by that edge.
// ---------------------------------------------------------------------------
module tb_pixel_row_requester;

    localparam int REFRACT = 4;
`ifdef PIXEL_REFRACT_EN
    localparam int EXP_GAP = 2 + REFRACT;
`else
    localparam int EXP_GAP = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] evt;
    logic [7:0] pol;
    logic       row_gnt;
    logic [7:0] col_gnt;
    logic       row_req;
    logic       col_en;
    logic [7:0] col_req;
    logic       evt_valid;
    logic [2:0] evt_col;
    logic       evt_pol;
    logic       overrun;
    logic [4:0] ev;

    int total = 0;
    int bad   = 0;

    assign ev = {evt_valid, evt_col, evt_pol};

    always #5 clk = ~clk;

    pixel_row_requester #(
        .REFRACT_CYC(REFRACT)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .evt_i      (evt),
        .pol_i      (pol),
        .row_req_o  (row_req),
        .row_gnt_i  (row_gnt),
        .col_en_o   (col_en),
        .col_req_o  (col_req),
        .col_gnt_i  (col_gnt),
        .evt_valid_o(evt_valid),
        .evt_col_o  (evt_col),
        .evt_pol_o  (evt_pol),
        .overrun_o  (overrun)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // After a DONE cycle has been observed, advance until the block is IDLE.
    task automatic settle();
`ifdef PIXEL_REFRACT_EN
        repeat (REFRACT + 1) cyc();
`else
        cyc();
`endif
    endtask

    // From IDLE with something pending and row_gnt high: ROW_REQ, SCAN_WAIT, SCAN.
    task automatic enter_scan(input string tag);
        cyc();
        total++; if ({row_req, col_en} !== 2'b10) begin bad++; $display("[TB] FAIL %s_rowreq: req/en=%b want 10", tag, {row_req, col_en}); end
        cyc();
        total++; if ({row_req, col_en} !== 2'b11) begin bad++; $display("[TB] FAIL %s_scanwait: req/en=%b want 11", tag, {row_req, col_en}); end
        cyc();
        total++; if ({row_req, col_en} !== 2'b11) begin bad++; $display("[TB] FAIL %s_scan: req/en=%b want 11", tag, {row_req, col_en}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; evt = '0; pol = '0; row_gnt = 1'b0; col_gnt = '0;
        #12;
        total++; if ({row_req, col_en} !== 2'b00) begin bad++; $display("[TB] FAIL rst_req_en: got %b want 00", {row_req, col_en}); end
        total++; if (col_req !== 8'h00) begin bad++; $display("[TB] FAIL rst_col_req: got %h want 00", col_req); end
        total++; if (ev !== 5'b0) begin bad++; $display("[TB] FAIL rst_evt: got %b want 00000", ev); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL rst_overrun: got %b want 0", overrun); end
        @(negedge clk); rst_n = 1'b1;
        evt = 8'h81; pol = 8'h81;
        cyc();
        evt = '0; pol = '0;
        total++; if (col_req !== 8'h81) begin bad++; $display("[TB] FAIL rst_latch: got %h want 81", col_req); end
        #2; rst_n = 1'b0; #1;
        total++; if (col_req !== 8'h00) begin bad++; $display("[TB] FAIL rst_async: got %h want 00", col_req); end
        @(negedge clk); rst_n = 1'b1;
        cyc();
        total++; if ({row_req, col_req} !== 9'h000) begin bad++; $display("[TB] FAIL rst_after: req=%b col_req=%h want 0/00", row_req, col_req); end
    endtask

    task automatic test_basic();
        row_gnt = 1'b1;
        evt = 8'h05; pol = 8'h04;
        cyc();
        evt = '0; pol = '0;
        total++; if (col_req !== 8'h05) begin bad++; $display("[TB] FAIL basic_pend: got %h want 05", col_req); end
        enter_scan("basic");
        col_gnt = 8'h01;
        cyc();
        total++; if (ev !== {1'b1, 3'd0, 1'b0}) begin bad++; $display("[TB] FAIL basic_ev0: got %b want 10000", ev); end
        total++; if (col_req !== 8'h04) begin bad++; $display("[TB] FAIL basic_pend0: got %h want 04", col_req); end
        col_gnt = 8'h04;
        cyc();
        total++; if (ev !== {1'b1, 3'd2, 1'b1}) begin bad++; $display("[TB] FAIL basic_ev2: got %b want 10101", ev); end
        col_gnt = 8'h00;
        cyc();
        total++; if ({row_req, col_en} !== 2'b00) begin bad++; $display("[TB] FAIL basic_done: req/en=%b want 00", {row_req, col_en}); end
        total++; if (ev !== {1'b0, 3'd2, 1'b1}) begin bad++; $display("[TB] FAIL basic_hold: got %b want 00101", ev); end
        total++; if (col_req !== 8'h00) begin bad++; $display("[TB] FAIL basic_pend_end: got %h want 00", col_req); end
        settle();
    endtask

    task automatic test_overrun();
        row_gnt = 1'b1;
        evt = 8'h08; pol = 8'h08;
        cyc();
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_first: got %b want 0", overrun); end
        evt = 8'h08; pol = 8'h00;
        cyc();
        evt = '0;
        total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_pulse: got %b want 1", overrun); end
        total++; if (row_req !== 1'b1) begin bad++; $display("[TB] FAIL ovr_rowreq: got %b want 1", row_req); end
        cyc();
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_once: got %b want 0", overrun); end
        col_gnt = 8'h08;
        cyc();
        total++; if ({evt_valid, col_req} !== 9'h008) begin bad++; $display("[TB] FAIL ovr_sw_ignore: valid=%b col_req=%h want 0/08", evt_valid, col_req); end
        cyc();
        total++; if (ev !== {1'b1, 3'd3, 1'b1}) begin bad++; $display("[TB] FAIL ovr_ev: got %b want 10111", ev); end
        total++; if (col_req !== 8'h00) begin bad++; $display("[TB] FAIL ovr_clear: got %h want 00", col_req); end
        col_gnt = 8'h00;
        cyc();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_single: got %b want 0", evt_valid); end
        settle();
    endtask

    task automatic test_evt_during_grant();
        row_gnt = 1'b1;
        evt = 8'h02; pol = 8'h00;
        cyc();
        evt = '0;
        enter_scan("race");
        col_gnt = 8'h02; evt = 8'h02; pol = 8'h02;
        cyc();
        evt = '0; pol = '0; col_gnt = 8'h00;
        total++; if (ev !== {1'b1, 3'd1, 1'b0}) begin bad++; $display("[TB] FAIL race_ev1: got %b want 10010", ev); end
        total++; if (col_req !== 8'h02) begin bad++; $display("[TB] FAIL race_pend: got %h want 02", col_req); end
        total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL race_ovr: got %b want 0", overrun); end
        cyc();
        settle();
        enter_scan("race2");
        col_gnt = 8'h02;
        cyc();
        col_gnt = 8'h00;
        total++; if (ev !== {1'b1, 3'd1, 1'b1}) begin bad++; $display("[TB] FAIL race_ev2: got %b want 10011", ev); end
        total++; if (col_req !== 8'h00) begin bad++; $display("[TB] FAIL race_clear: got %h want 00", col_req); end
        cyc();
        settle();
    endtask

    task automatic test_no_grant();
        row_gnt = 1'b0;
        evt = 8'h10; pol = 8'h00;
        cyc();
        evt = '0;
        cyc();
        for (int i = 0; i < 20; i++) begin
            total++; if ({row_req, col_en, evt_valid} !== 3'b100) begin bad++; $display("[TB] FAIL nogrant_%0d: req/en/valid=%b want 100", i, {row_req, col_en, evt_valid}); end
            cyc();
        end
        row_gnt = 1'b1;
        cyc();
        cyc();
        col_gnt = 8'h10;
        cyc();
        col_gnt = 8'h00;
        total++; if (ev !== {1'b1, 3'd4, 1'b0}) begin bad++; $display("[TB] FAIL nogrant_ev: got %b want 11000", ev); end
        cyc();
        settle();
    endtask

    task automatic test_abort();
        row_gnt = 1'b1;
        evt = 8'h0E; pol = 8'h0A;
        cyc();
        evt = '0; pol = '0;
        enter_scan("abort");
        col_gnt = 8'h02;
        cyc();
        total++; if (ev !== {1'b1, 3'd1, 1'b1}) begin bad++; $display("[TB] FAIL abort_ev1: got %b want 10011", ev); end
        row_gnt = 1'b0; col_gnt = 8'h04;
        cyc();
        col_gnt = 8'h00;
        total++; if ({row_req, col_en} !== 2'b00) begin bad++; $display("[TB] FAIL abort_done: req/en=%b want 00", {row_req, col_en}); end
        total++; if (col_req !== 8'h0C) begin bad++; $display("[TB] FAIL abort_pend: got %h want 0c", col_req); end
        total++; if (ev !== {1'b0, 3'd1, 1'b1}) begin bad++; $display("[TB] FAIL abort_noev: got %b want 00011", ev); end
        row_gnt = 1'b1;
        settle();
        enter_scan("abort2");
        col_gnt = 8'h04;
        cyc();
        total++; if (ev !== {1'b1, 3'd2, 1'b0}) begin bad++; $display("[TB] FAIL abort_ev2: got %b want 10100", ev); end
        col_gnt = 8'h08;
        cyc();
        col_gnt = 8'h00;
        total++; if (ev !== {1'b1, 3'd3, 1'b1}) begin bad++; $display("[TB] FAIL abort_ev3: got %b want 10111", ev); end
        total++; if (col_req !== 8'h00) begin bad++; $display("[TB] FAIL abort_clear: got %h want 00", col_req); end
        cyc();
        settle();
    endtask

    task automatic test_nonhot();
        row_gnt = 1'b1;
        evt = 8'h06; pol = 8'h04;
        cyc();
        evt = '0; pol = '0;
        enter_scan("nonhot");
        col_gnt = 8'h06;
        cyc();
        total++; if (ev !== {1'b1, 3'd1, 1'b0}) begin bad++; $display("[TB] FAIL nonhot_ev: got %b want 10010", ev); end
        total++; if (col_req !== 8'h04) begin bad++; $display("[TB] FAIL nonhot_pend: got %h want 04", col_req); end
        col_gnt = 8'h04;
        cyc();
        col_gnt = 8'h00;
        total++; if (ev !== {1'b1, 3'd2, 1'b1}) begin bad++; $display("[TB] FAIL nonhot_ev2: got %b want 10101", ev); end
        cyc();
        settle();
    endtask

    task automatic test_reset_mid_scan();
        row_gnt = 1'b1;
        evt = 8'h03; pol = 8'h03;
        cyc();
        evt = '0; pol = '0;
        enter_scan("rstmid");
        col_gnt = 8'h01;
        cyc();
        total++; if (ev !== {1'b1, 3'd0, 1'b1}) begin bad++; $display("[TB] FAIL rstmid_ev0: got %b want 10001", ev); end
        col_gnt = 8'h02;
        #2; rst_n = 1'b0; #1;
        total++; if ({row_req, col_en, col_req} !== 10'h000) begin bad++; $display("[TB] FAIL rstmid_async: req/en=%b col_req=%h want 00/00", {row_req, col_en}, col_req); end
        total++; if (ev !== 5'b0) begin bad++; $display("[TB] FAIL rstmid_ev: got %b want 00000", ev); end
        col_gnt = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        cyc();
        cyc();
        total++; if ({row_req, evt_valid} !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_quiet: req/valid=%b want 00", {row_req, evt_valid}); end
    endtask

    task automatic test_refract();
        int gap;
        row_gnt = 1'b1;
        evt = 8'h01; pol = 8'h00;
        cyc();
        evt = '0;
        enter_scan("refr");
        col_gnt = 8'h01; evt = 8'h20; pol = 8'h20;
        cyc();
        evt = '0; pol = '0;
        total++; if (ev !== {1'b1, 3'd0, 1'b0}) begin bad++; $display("[TB] FAIL refr_ev0: got %b want 10000", ev); end
        total++; if (col_req !== 8'h20) begin bad++; $display("[TB] FAIL refr_pend: got %h want 20", col_req); end
        col_gnt = 8'h00;
        cyc();
        total++; if ({row_req, col_req} !== 9'h020) begin bad++; $display("[TB] FAIL refr_done: req=%b col_req=%h want 0/20", row_req, col_req); end
        gap = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (row_req) break;
            gap++;
        end
        total++; if (gap !== EXP_GAP) begin bad++; $display("[TB] FAIL refr_gap: got %0d low cycles want %0d", gap, EXP_GAP); end
        cyc();
        cyc();
        col_gnt = 8'h20;
        cyc();
        col_gnt = 8'h00;
        total++; if (ev !== {1'b1, 3'd5, 1'b1}) begin bad++; $display("[TB] FAIL refr_ev5: got %b want 11011", ev); end
        cyc();
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_evt_during_grant();
        test_no_grant();
        test_abort();
        test_nonhot();
        test_reset_mid_scan();
        test_refract();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
